// File: rtl/bram_port_arbiter_if.sv
// bram_port_arbiter_if
// Bundles the two requester ports and the block-RAM pins shared through bram_port_arbiter.
//   Requester side : req0/1, we0/1, addr0/1, wdata0/1, lock0/1 (to arbiter)
//                    gnt0/1, rvalid0/1, rdata (from arbiter)
//   RAM side       : ram_addra, ram_addrb, ram_dina, ram_wea (from arbiter), ram_doutb (to arbiter)
// Modports: slave = arbiter view, master = requesters + RAM view.
interface bram_port_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 14
);
  logic                  req0;
  logic                  req1;
  logic [3:0]            we0;
  logic [3:0]            we1;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [31:0]           wdata0;
  logic [31:0]           wdata1;
  logic                  lock0;
  logic                  lock1;
  logic                  gnt0;
  logic                  gnt1;
  logic                  rvalid0;
  logic                  rvalid1;
  logic [31:0]           rdata;
  logic [ADDR_WIDTH-1:0] ram_addra;
  logic [ADDR_WIDTH-1:0] ram_addrb;
  logic [31:0]           ram_dina;
  logic [3:0]            ram_wea;
  logic [31:0]           ram_doutb;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, lock0, lock1, ram_doutb,
    output gnt0, gnt1, rvalid0, rvalid1, rdata, ram_addra, ram_addrb, ram_dina, ram_wea
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, lock0, lock1, ram_doutb,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata, ram_addra, ram_addrb, ram_dina, ram_wea
  );
endinterface

// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter
// Shares one simple-dual-port block RAM between two requesters, one access per cycle.
// Grants are combinational; a lock keeps ownership for back-to-back bursts. Reads return
// one cycle after acceptance with a per-port valid strobe; rdata is the RAM output.
// Ports:
//   clka : rising-edge clock (also clocks the RAM)
//   rsta : synchronous active-high reset
//   bus  : bram_port_arbiter_if.slave (requester handshakes and RAM pins)
// Build option: define BRAM_ARB_RR_EN for round-robin contention in idle; otherwise port 0
// has fixed priority.
module bram_port_arbiter (
  input logic                 clka,
  input logic                 rsta,
  bram_port_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} state_e;

  state_e r_state;
  logic   r_pend0;
  logic   r_pend1;
  logic   w_gnt0;
  logic   w_gnt1;
  logic   w_p0_wins;
  logic   w_contend;

`ifdef BRAM_ARB_RR_EN
  logic   r_last1;  // 1: port 1 won the last contended grant
  assign w_p0_wins = r_last1;
`else
  assign w_p0_wins = 1'b1;
`endif

  assign w_contend = (r_state == StIdle) && bus.req0 && bus.req1;

  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (!rsta) begin
      case (r_state)
        StOwn0: w_gnt0 = bus.req0;
        StOwn1: w_gnt1 = bus.req1;
        default: begin
          if (w_contend) begin
            w_gnt0 = w_p0_wins;
            w_gnt1 = ~w_p0_wins;
          end else begin
            w_gnt0 = bus.req0;
            w_gnt1 = bus.req1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clka) begin
    if (rsta) begin
      r_state <= StIdle;
      r_pend0 <= 1'b0;
      r_pend1 <= 1'b0;
`ifdef BRAM_ARB_RR_EN
      r_last1 <= 1'b1;
`endif
    end else begin
      r_pend0 <= w_gnt0 && (bus.we0 == 4'b0000);
      r_pend1 <= w_gnt1 && (bus.we1 == 4'b0000);
`ifdef BRAM_ARB_RR_EN
      if (w_contend) r_last1 <= w_gnt1;
`endif
      case (r_state)
        StIdle: begin
          if (w_gnt0 && bus.lock0)      r_state <= StOwn0;
          else if (w_gnt1 && bus.lock1) r_state <= StOwn1;
        end
        // In OWNn gnt equals reqn, so staying needs an accepted access that keeps the lock.
        StOwn0:  if (!(bus.req0 && bus.lock0)) r_state <= StIdle;
        StOwn1:  if (!(bus.req1 && bus.lock1)) r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.gnt0 = w_gnt0;
  assign bus.gnt1 = w_gnt1;

  // Port 0 values are driven whenever port 1 is not granted.
  assign bus.ram_addra = w_gnt1 ? bus.addr1  : bus.addr0;
  assign bus.ram_addrb = w_gnt1 ? bus.addr1  : bus.addr0;
  assign bus.ram_dina  = w_gnt1 ? bus.wdata1 : bus.wdata0;
  assign bus.ram_wea   = w_gnt0 ? bus.we0 : (w_gnt1 ? bus.we1 : 4'b0000);

  // Mask the pending tag while reset is held so a read accepted just before reset is dropped.
  assign bus.rvalid0 = r_pend0 & ~rsta;
  assign bus.rvalid1 = r_pend1 & ~rsta;
  assign bus.rdata   = bus.ram_doutb;

endmodule

// File: tb/tb_bram_port_arbiter.sv
module tb_bram_port_arbiter;
  localparam int unsigned AW = 14;

  logic clka = 1'b0;
  logic rsta;
  always #5 clka = ~clka;

  bram_port_arbiter_if #(.ADDR_WIDTH(AW)) bus ();

  bram_port_arbiter dut (
    .clka (clka),
    .rsta (rsta),
    .bus  (bus.slave)
  );

  // Simple-dual-port RAM with registered read; tests use addresses 0..15.
  logic [31:0] ram_mem [0:15];
  always @(posedge clka) begin
    for (int b = 0; b < 4; b++) begin
      if (bus.ram_wea[b]) ram_mem[bus.ram_addra[3:0]][8*b +: 8] <= bus.ram_dina[8*b +: 8];
    end
    bus.ram_doutb <= ram_mem[bus.ram_addrb[3:0]];
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Reference model: owner is -1 (nobody), 0 or 1; shadow holds expected memory contents.
  int          m_owner = -1;
  bit          m_p0_first = 1'b1;
  bit          m_pend0 = 1'b0;
  bit          m_pend1 = 1'b0;
  logic [31:0] m_exp = '0;
  logic [31:0] shadow [0:15];
  bit          mg0, mg1;

  task automatic cyc(input bit rst,
                     input bit r0, input logic [3:0] w0, input logic [3:0] a0,
                     input logic [31:0] d0, input bit l0,
                     input bit r1, input logic [3:0] w1, input logic [3:0] a1,
                     input logic [31:0] d1, input bit l1);
    logic [3:0]  exp_wea;
    logic [3:0]  exp_a;
    logic [31:0] exp_d;
    @(negedge clka);
    rsta = rst;
    bus.req0 = r0; bus.we0 = w0; bus.addr0 = '0; bus.addr0[3:0] = a0;
    bus.wdata0 = d0; bus.lock0 = l0;
    bus.req1 = r1; bus.we1 = w1; bus.addr1 = '0; bus.addr1[3:0] = a1;
    bus.wdata1 = d1; bus.lock1 = l1;
    #1;
    mg0 = 1'b0;
    mg1 = 1'b0;
    if (!rst) begin
      if (m_owner == 0) mg0 = r0;
      else if (m_owner == 1) mg1 = r1;
      else if (r0 && r1) begin
`ifdef BRAM_ARB_RR_EN
        mg0 = m_p0_first;
`else
        mg0 = 1'b1;
`endif
        mg1 = !mg0;
      end else begin
        mg0 = r0;
        mg1 = r1;
      end
    end
    check("gnt0", bus.gnt0, mg0);
    check("gnt1", bus.gnt1, mg1);
    exp_wea = mg0 ? w0 : (mg1 ? w1 : 4'b0000);
    check("ram_wea", bus.ram_wea, exp_wea);
    if (mg0 || mg1) begin
      exp_a = mg1 ? a1 : a0;
      exp_d = mg1 ? d1 : d0;
      check("ram_addra", bus.ram_addra, exp_a);
      check("ram_addrb", bus.ram_addrb, exp_a);
      check("ram_dina", bus.ram_dina, exp_d);
    end
    check("rvalid0", bus.rvalid0, !rst && m_pend0);
    check("rvalid1", bus.rvalid1, !rst && m_pend1);
    if (!rst && (m_pend0 || m_pend1)) check("rdata", bus.rdata, m_exp);

    if (rst) begin
      m_owner = -1; m_p0_first = 1'b1; m_pend0 = 1'b0; m_pend1 = 1'b0;
    end else begin
      m_pend0 = mg0 && (w0 == 4'b0000);
      m_pend1 = mg1 && (w1 == 4'b0000);
      if (m_pend0) m_exp = shadow[a0];
      if (m_pend1) m_exp = shadow[a1];
      for (int b = 0; b < 4; b++) begin
        if (mg0 && w0[b]) shadow[a0][8*b +: 8] = d0[8*b +: 8];
        if (mg1 && w1[b]) shadow[a1][8*b +: 8] = d1[8*b +: 8];
      end
      if (m_owner == -1) begin
        if (r0 && r1) m_p0_first = mg1;
        if (mg0 && l0) m_owner = 0;
        else if (mg1 && l1) m_owner = 1;
      end else if (m_owner == 0) begin
        if (!(r0 && l0)) m_owner = -1;
      end else begin
        if (!(r1 && l1)) m_owner = -1;
      end
    end
  endtask

  task automatic idle(input bit rst);
    cyc(rst, 0, 4'h0, 4'h0, 32'h0, 0, 0, 4'h0, 4'h0, 32'h0, 0);
  endtask

  bit          h0, h1, hl0, hl1, rr;
  logic [3:0]  hw0, hw1, ha0, ha1;
  logic [31:0] hd0, hd1;
  bit          exp_g0, prev_g0;

  initial begin
    rsta = 1'b1;
    bus.req0 = 0; bus.req1 = 0; bus.lock0 = 0; bus.lock1 = 0;
    bus.we0 = '0; bus.we1 = '0; bus.addr0 = '0; bus.addr1 = '0;
    bus.wdata0 = '0; bus.wdata1 = '0;
    for (int i = 0; i < 16; i++) shadow[i] = '0;
    idle(1);
    idle(1);
    idle(0);
    for (int i = 0; i < 16; i++) cyc(0, 1, 4'hF, 4'(i), $urandom, 0, 0, 4'h0, 4'h0, 32'h0, 0);

    // Full-word write then read-back on port 0
    cyc(0, 1, 4'hF, 4'd5, 32'hDEADBEEF, 0, 0, 4'h0, 4'h0, 32'h0, 0);
    cyc(0, 1, 4'h0, 4'd5, 32'h0, 0, 0, 4'h0, 4'h0, 32'h0, 0);
    idle(0);
    check("wr_rd_rvalid0", bus.rvalid0, 1'b1);
    check("wr_rd_rdata", bus.rdata, 32'hDEADBEEF);
    check("wr_rd_rvalid1", bus.rvalid1, 1'b0);

    // Byte-enable write on port 1
    cyc(0, 1, 4'hF, 4'd9, 32'h11223344, 0, 0, 4'h0, 4'h0, 32'h0, 0);
    cyc(0, 0, 4'h0, 4'h0, 32'h0, 0, 1, 4'b0101, 4'd9, 32'hAABBCCDD, 0);
    cyc(0, 0, 4'h0, 4'h0, 32'h0, 0, 1, 4'h0, 4'd9, 32'h0, 0);
    idle(0);
    check("byte_rvalid1", bus.rvalid1, 1'b1);
    check("byte_rdata", bus.rdata, 32'h11BB33DD);

    // Continuous contention right after reset
    idle(1);
    prev_g0 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc(0, 1, 4'h0, 4'd1, 32'h0, 0, 1, 4'h0, 4'd2, 32'h0, 0);
`ifdef BRAM_ARB_RR_EN
      exp_g0 = (i % 2 == 0);
`else
      exp_g0 = 1'b1;
`endif
      check("cont_gnt0", bus.gnt0, exp_g0);
      check("cont_gnt1", bus.gnt1, !exp_g0);
      if (i > 0) check("cont_rvalid0", bus.rvalid0, prev_g0);
      prev_g0 = exp_g0;
    end
    idle(0);
    check("cont_last_rvalid0", bus.rvalid0, prev_g0);
    check("cont_last_rvalid1", bus.rvalid1, !prev_g0);

    // Locked 4-beat write burst on port 1 while port 0 waits
    cyc(0, 0, 4'h0, 4'd5, 32'h0, 0, 1, 4'hF, 4'd0, 32'hA0A0A0A0, 1);
    check("burst_gnt1_b1", bus.gnt1, 1'b1);
    for (int i = 1; i < 4; i++) begin
      cyc(0, 1, 4'h0, 4'd5, 32'h0, 0, 1, 4'hF, 4'(i), $urandom, (i < 3));
      check("burst_gnt0", bus.gnt0, 1'b0);
      check("burst_gnt1", bus.gnt1, 1'b1);
    end
    cyc(0, 1, 4'h0, 4'd5, 32'h0, 0, 0, 4'h0, 4'h0, 32'h0, 0);
    check("burst_after_gnt0", bus.gnt0, 1'b1);

    // Reset right after an accepted read
    cyc(0, 1, 4'h0, 4'd5, 32'h0, 0, 0, 4'h0, 4'h0, 32'h0, 0);
    cyc(1, 1, 4'hF, 4'd6, 32'h12345678, 0, 1, 4'hF, 4'd7, 32'h0, 0);
    check("rst_rvalid0", bus.rvalid0, 1'b0);
    check("rst_gnt0", bus.gnt0, 1'b0);
    check("rst_gnt1", bus.gnt1, 1'b0);
    check("rst_wea", bus.ram_wea, 4'h0);
    cyc(0, 1, 4'h0, 4'd3, 32'h0, 0, 1, 4'h0, 4'd4, 32'h0, 0);
    check("post_rst_gnt0", bus.gnt0, 1'b1);
    check("post_rst_gnt1", bus.gnt1, 1'b0);

    // Port 1 locks then drops its request
    cyc(0, 0, 4'h0, 4'h0, 32'h0, 0, 1, 4'h0, 4'd8, 32'h0, 1);
    check("drop_gnt1", bus.gnt1, 1'b1);
    cyc(0, 1, 4'h0, 4'd2, 32'h0, 0, 0, 4'h0, 4'h0, 32'h0, 0);
    check("drop_gnt0_owned", bus.gnt0, 1'b0);
    cyc(0, 1, 4'h0, 4'd2, 32'h0, 0, 0, 4'h0, 4'h0, 32'h0, 0);
    check("drop_gnt0_released", bus.gnt0, 1'b1);
    idle(0);

    // Random traffic; each requester holds its request until granted
    h0 = 0; h1 = 0;
    for (int i = 0; i < 600; i++) begin
      if (!h0 && ($urandom % 3 != 0)) begin
        h0 = 1; hw0 = ($urandom % 2 == 0) ? 4'h0 : 4'($urandom);
        ha0 = 4'($urandom); hd0 = $urandom; hl0 = ($urandom % 3 == 0);
      end
      if (!h1 && ($urandom % 3 != 0)) begin
        h1 = 1; hw1 = ($urandom % 2 == 0) ? 4'h0 : 4'($urandom);
        ha1 = 4'($urandom); hd1 = $urandom; hl1 = ($urandom % 3 == 0);
      end
      rr = ($urandom % 60 == 0);
      cyc(rr, h0, hw0, ha0, hd0, hl0, h1, hw1, ha1, hd1, hl1);
      if (mg0) h0 = 0;
      if (mg1) h1 = 0;
    end
    idle(0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
